// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/pause/single-step clock-enable controller for a soft CPU core

// Two-flop synchronizer followed by a level debouncer
module cpu_step_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // bring the asynchronous input into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], din};
   end

   // accept a new level only after DEB_CYCLES consecutive samples that differ from the current one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync[1] == dout) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
         dout <= sync[1];
         cnt  <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// Step / run / halt sequencer producing the core clock enable and reset
module cpu_step_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int BASE_DIV   = 100000000,
   parameter int RST_HOLD   = 16
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic [1:0]  speed_sel,
   input  logic        halt_req,
   output logic        cpu_ce,
   output logic        cpu_rst,
   output logic [1:0]  mode,
   output logic [15:0] step_cnt,
   output logic        beat
);
   localparam int DIV_MID  = (BASE_DIV / 10  > 0) ? BASE_DIV / 10  : 1;
   localparam int DIV_FAST = (BASE_DIV / 100 > 0) ? BASE_DIV / 100 : 1;
   localparam int DW       = $clog2(BASE_DIV + 1);
   localparam int HW       = $clog2(RST_HOLD + 1);

   typedef enum logic [1:0] {
      S_HOLD  = 2'b00,
      S_PAUSE = 2'b01,
      S_RUN   = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   state_t        state;
   logic [1:0]    rel_q;
   logic [HW-1:0] hold_cnt;
   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_max;
   logic [1:0]    spd_q;
   logic          run_deb;
   logic          step_deb;
   logic          step_prev;
   logic          step_evt;
   logic          spd_chg;

   cpu_step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .din   (run_sw),
      .dout  (run_deb)
   );

   cpu_step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .din   (step_btn),
      .dout  (step_deb)
   );

   assign step_evt = step_deb & ~step_prev;
   assign spd_chg  = (speed_sel != spd_q);
   assign mode     = state;

   // terminal divider count for the selected run rate; 0 means a pulse every cycle
   always_comb begin
      div_max = '0;
      case (speed_sel)
         2'b00:   div_max = DW'(BASE_DIV - 1);
         2'b01:   div_max = DW'(DIV_MID - 1);
         2'b10:   div_max = DW'(DIV_FAST - 1);
         default: div_max = '0;
      endcase
   end

   // reset-release synchronizer, step edge history, speed history, pulse counter and beat LED
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         rel_q     <= '0;
         step_prev <= 1'b0;
         spd_q     <= '0;
         step_cnt  <= '0;
         beat      <= 1'b0;
      end else begin
         rel_q     <= {rel_q[0], 1'b1};
         step_prev <= step_deb;
         spd_q     <= speed_sel;
         if (cpu_ce) begin
            step_cnt <= step_cnt + 16'd1;
            beat     <= ~beat;
         end
      end
   end

   // main sequencer; cpu_ce defaults low so every pulse is exactly one cycle wide
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state    <= S_HOLD;
         hold_cnt <= '0;
         div_cnt  <= '0;
         cpu_ce   <= 1'b0;
         cpu_rst  <= 1'b1;
      end else begin
         cpu_ce <= 1'b0;
         case (state)
            S_HOLD: begin
               cpu_rst <= 1'b1;
               if (rel_q[1]) begin
                  if (hold_cnt == HW'(RST_HOLD - 1)) begin
                     cpu_rst <= 1'b0;
                     div_cnt <= '0;
                     state   <= run_deb ? S_RUN : S_PAUSE;
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
            end
            S_PAUSE: begin
               if (halt_req) begin
                  state <= S_HALT;
               end else if (run_deb) begin
                  state   <= S_RUN;
                  div_cnt <= '0;
               end else if (step_evt) begin
                  cpu_ce <= 1'b1;
               end
            end
            S_RUN: begin
               if (halt_req) begin
                  state <= S_HALT;
               end else if (!run_deb) begin
                  state <= S_PAUSE;
               end else if (spd_chg) begin
                  div_cnt <= '0;
               end else if (div_cnt >= div_max) begin
                  div_cnt <= '0;
                  cpu_ce  <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_HALT: begin
               if (step_evt && !run_deb) state <= S_PAUSE;
            end
            default: state <= S_HOLD;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - randomized self-checking bench for cpu_step_ctrl with a behavioural model

module tb_cpu_step_ctrl;
   localparam int DEB      = 4;
   localparam int BASE_DIV = 100;
   localparam int RST_HOLD = 16;

   logic        clk;
   logic        rstn;
   logic        run_sw;
   logic        step_btn;
   logic [1:0]  speed_sel;
   logic        halt_req;
   logic        cpu_ce;
   logic        cpu_rst;
   logic [1:0]  mode;
   logic [15:0] step_cnt;
   logic        beat;

   int n_cmp = 0;
   int n_bad = 0;
   int ec    = 0;
   int n_ce  = 0;
   int ce_t[$];

   // behavioural model state
   int          k;
   int          m_mode;
   bit          m_ce;
   bit          m_rst;
   int          m_cnt;
   bit          m_beat;
   bit          m_run_deb;
   bit          m_step_deb;
   bit          m_step_prev;
   logic [1:0]  prev_speed;
   int          anchor;
   logic [15:0] run_r;
   logic [15:0] step_r;

   cpu_step_ctrl #(.DEB_CYCLES(DEB), .BASE_DIV(BASE_DIV), .RST_HOLD(RST_HOLD)) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rstn),
      .run_sw     (run_sw),
      .step_btn   (step_btn),
      .speed_sel  (speed_sel),
      .halt_req   (halt_req),
      .cpu_ce     (cpu_ce),
      .cpu_rst    (cpu_rst),
      .mode       (mode),
      .step_cnt   (step_cnt),
      .beat       (beat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int div_of(input logic [1:0] s);
      case (s)
         2'd0:    return BASE_DIV;
         2'd1:    return BASE_DIV / 10;
         2'd2:    return BASE_DIV / 100;
         default: return 1;
      endcase
   endfunction

   // r[j] holds the raw input sampled j+1 edges ago; the debouncer sees r[1] and older
   function automatic bit flips(input bit cur, input logic [15:0] r);
      logic [DEB-1:0] w;
      w = r[DEB:1];
      return cur ? (w == '0) : (w == '1);
   endfunction

   task automatic model_reset();
      k = 0; m_mode = 0; m_ce = 1'b0; m_rst = 1'b1; m_cnt = 0; m_beat = 1'b0;
      m_run_deb = 1'b0; m_step_deb = 1'b0; m_step_prev = 1'b0;
      prev_speed = 2'd0; anchor = 0; run_r = '0; step_r = '0;
   endtask

   task automatic model_edge();
      bit evt;
      bit ce_nx;
      int dv;
      k++;
      evt   = m_step_deb && !m_step_prev;
      ce_nx = 1'b0;
      dv    = div_of(speed_sel);
      case (m_mode)
         0: if (k == 2 + RST_HOLD) begin
               m_rst  = 1'b0;
               anchor = k;
               m_mode = m_run_deb ? 2 : 1;
            end
         1: if (halt_req) m_mode = 3;
            else if (m_run_deb) begin m_mode = 2; anchor = k; end
            else if (evt) ce_nx = 1'b1;
         2: if (halt_req) m_mode = 3;
            else if (!m_run_deb) m_mode = 1;
            else if (speed_sel != prev_speed) anchor = k;
            else if ((k - anchor) % dv == 0) ce_nx = 1'b1;
         default: if (evt && !m_run_deb) m_mode = 1;
      endcase
      if (m_ce) begin
         m_cnt  = (m_cnt + 1) % 65536;
         m_beat = !m_beat;
      end
      m_ce        = ce_nx;
      m_step_prev = m_step_deb;
      if (flips(m_run_deb, run_r))   m_run_deb  = !m_run_deb;
      if (flips(m_step_deb, step_r)) m_step_deb = !m_step_deb;
      run_r      = {run_r[14:0], run_sw};
      step_r     = {step_r[14:0], step_btn};
      prev_speed = speed_sel;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else       model_edge();
      end
   end

   initial forever begin
      @(posedge clk);
      ec++;
   end

   // every-cycle comparison of all outputs against the model
   initial forever begin
      @(negedge clk);
      chk("cpu_ce",   int'(cpu_ce),   int'(m_ce));
      chk("cpu_rst",  int'(cpu_rst),  int'(m_rst));
      chk("mode",     int'(mode),     m_mode);
      chk("step_cnt", int'(step_cnt), m_cnt);
      chk("beat",     int'(beat),     int'(m_beat));
      if (cpu_ce) begin
         n_ce++;
         ce_t.push_back(ec);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press(input int hi, input int lo);
      step_btn = 1'b1;
      cyc(hi);
      step_btn = 1'b0;
      cyc(lo);
   endtask

   task automatic wait_mode(input int want, input string name);
      int i;
      i = 0;
      while (int'(mode) != want && i < 200) begin
         cyc(1);
         i++;
      end
      chk(name, int'(mode), want);
   endtask

   initial begin
      int n, n0, n1, t, nh, i;
      rstn = 1'b0; run_sw = 1'b0; step_btn = 1'b0; speed_sel = 2'd0; halt_req = 1'b0;
      cyc(3);
      chk("rst_cpu_rst", int'(cpu_rst), 1);
      chk("rst_cpu_ce", int'(cpu_ce), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_step_cnt", int'(step_cnt), 0);
      chk("rst_beat", int'(beat), 0);

      // release: two synchronizer edges plus RST_HOLD counting edges
      rstn = 1'b1;
      n = 0;
      while (cpu_rst && n < 100) begin
         cyc(1);
         n++;
      end
      chk("hold_edges", n, 18);
      chk("pause_after_hold", int'(mode), 1);
      cyc(150);
      chk("pause_no_ce", n_ce, 0);

      // glitchy press followed by a solid press
      step_btn = 1'b1; cyc(2); step_btn = 1'b0; cyc(2);
      step_btn = 1'b1; cyc(2); step_btn = 1'b0; cyc(3);
      press(10, 20);
      chk("step_one_pulse", n_ce, 1);
      chk("step_cnt_one", int'(step_cnt), 1);
      chk("beat_one", int'(beat), 1);

      // slow run rate, then a mid-count change to the /10 rate
      run_sw = 1'b1;
      wait_mode(2, "run_mode");
      n0 = ce_t.size();
      cyc(350);
      if (ce_t.size() >= n0 + 3) begin
         chk("period_a", ce_t[n0+1] - ce_t[n0], 100);
         chk("period_b", ce_t[n0+2] - ce_t[n0+1], 100);
      end else chk("period_pulses", ce_t.size() - n0, 3);
      speed_sel = 2'd1;
      cyc(1);
      t  = ec;
      n1 = ce_t.size();
      cyc(30);
      if (ce_t.size() >= n1 + 2) begin
         chk("speed_chg_gap", ce_t[n1] - t, 10);
         chk("speed_mid_period", ce_t[n1+1] - ce_t[n1], 10);
      end else chk("speed_chg_pulses", ce_t.size() - n1, 2);

      // halt from full speed, then the two ways a step behaves in HALT
      speed_sel = 2'd3;
      cyc(20);
      halt_req = 1'b1;
      cyc(1);
      halt_req = 1'b0;
      chk("halt_mode", int'(mode), 3);
      chk("halt_ce", int'(cpu_ce), 0);
      nh = n_ce;
      cyc(20);
      chk("halt_quiet", n_ce - nh, 0);
      press(8, 12);
      chk("halt_step_run1", int'(mode), 3);
      run_sw = 1'b0;
      cyc(12);
      nh = n_ce;
      press(8, 12);
      chk("halt_step_run0", int'(mode), 1);
      chk("halt_exit_no_ce", n_ce - nh, 0);

      // randomized traffic; the every-cycle comparison does the checking
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 5))
            0: run_sw = !run_sw;
            1: begin step_btn = 1'b1; cyc($urandom_range(1, 12)); step_btn = 1'b0; end
            2: speed_sel = 2'($urandom_range(0, 3));
            3: begin halt_req = 1'b1; cyc(1); halt_req = 1'b0; end
            4: begin run_sw = !run_sw; cyc($urandom_range(1, 4)); run_sw = !run_sw; end
            default: repeat ($urandom_range(1, 6)) begin step_btn = 1'($urandom); cyc(1); end
         endcase
         cyc($urandom_range(1, 40));
      end
      step_btn = 1'b0; halt_req = 1'b0; run_sw = 1'b0;
      cyc(12);
      press(8, 12);

      // counter wrap: run fast up to near the top, then single-step across it
      speed_sel = 2'd3;
      run_sw = 1'b1;
      i = 0;
      while (m_cnt < 16'hFFF0 && i < 70000) begin
         cyc(1);
         i++;
      end
      if (i >= 70000) chk("wrap_reach_timeout", m_cnt, 16'hFFF0);
      run_sw = 1'b0;
      cyc(20);
      i = 0;
      while (m_cnt != 16'hFFFF && i < 40) begin
         press(8, 12);
         i++;
      end
      chk("cnt_ffff", int'(step_cnt), 16'hFFFF);
      press(8, 12);
      chk("cnt_wrap", int'(step_cnt), 0);

      // asynchronous reset between edges while running at full speed
      run_sw = 1'b1;
      cyc(20);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_ce", int'(cpu_ce), 0);
      chk("arst_rst", int'(cpu_rst), 1);
      chk("arst_mode", int'(mode), 0);
      chk("arst_cnt", int'(step_cnt), 0);
      chk("arst_beat", int'(beat), 0);
      nh = n_ce;
      cyc(5);
      chk("arst_quiet", n_ce - nh, 0);
      rstn = 1'b1;
      cyc(40);
      chk("rerun_mode", int'(mode), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: number of stable samples (10 ms at 100 MHz) before a debounced input changes.
REQ-002 Parameter BASE_DIV, default 100000000: clock cycles per core step at the slowest speed (1 Hz).
REQ-003 Parameter RST_HOLD, default 16: number of cycles cpu_rst stays asserted after reset release.
REQ-004 CLK100MHZ  in  1  the single clock; all state changes on its rising edge.
REQ-005 CPU_RESETN  in  1  asynchronous, active-low reset.
REQ-006 run_sw  in  1  asynchronous switch: 1 = free-run, 0 = pause.
REQ-007 step_btn  in  1  asynchronous pushbutton: each press issues one step while paused.
REQ-008 speed_sel  in  2  run rate: 00 = BASE_DIV, 01 = BASE_DIV/10, 10 = BASE_DIV/100, 11 = every cycle.
REQ-009 halt_req  in  1  synchronous signal from the core requesting a stop (for example, a terminal PC).
REQ-010 cpu_ce  out  1  single-cycle clock-enable pulse to the MIPS core.
REQ-011 cpu_rst  out  1  synchronous, active-high reset to the core and the display.
REQ-012 mode  out  2  current state encoding: 00 = HOLD, 01 = PAUSE, 10 = RUN, 11 = HALT.
REQ-013 step_cnt  out  16  count of cpu_ce pulses since reset.
REQ-014 beat  out  1  toggles on every cpu_ce pulse; drives an LED.

Function
REQ-015 run_sw and step_btn shall each pass through a 2-flop synchronizer and then a debouncer.
- Debounced value updates only after DEB_CYCLES consecutive equal synchronized samples differing from the current value.
REQ-016 A step event shall be a single-cycle pulse on the debounced step_btn 0->1 edge; release shall generate nothing.
REQ-017 FSM states shall be HOLD, PAUSE, RUN and HALT.
REQ-018 HOLD: cpu_rst = 1 and cpu_ce = 0; after RST_HOLD cycles the FSM goes to RUN if debounced run = 1, otherwise to PAUSE.
REQ-019 PAUSE: go to RUN when debounced run = 1; on a step event emit exactly one cpu_ce pulse in the following cycle and remain in PAUSE.
REQ-020 RUN: go to PAUSE when debounced run = 0.
REQ-021 RUN rate: a divider counter counts 0..DIV-1 and emits cpu_ce in the cycle the count equals DIV-1, then wraps to 0.
REQ-022 RUN at speed_sel = 11: cpu_ce = 1 on every cycle.
REQ-023 The divider shall clear to 0 on entry to RUN, so the first pulse occurs DIV cycles after entry.
REQ-024 A change of speed_sel shall clear the divider in the same cycle.
REQ-025 halt_req = 1 in PAUSE or RUN shall move the FSM to HALT on the next edge; halt_req has priority over run and step.
- No cpu_ce pulse is issued in the cycle halt_req is sampled.
REQ-026 HALT: cpu_ce = 0; leave only by a step event while debounced run = 0, which moves the FSM to PAUSE without emitting a pulse.
REQ-027 A step event in RUN or HOLD shall be ignored and shall not be queued.
REQ-028 A step event in the same cycle as a PAUSE->RUN transition shall be discarded.
REQ-029 step_cnt shall increment by 1 on every cpu_ce pulse and wrap from 0xFFFF to 0x0000.
REQ-030 cpu_ce shall never be high while cpu_rst is high.
REQ-031 cpu_ce, cpu_rst and mode shall be driven directly from registers, with no combinational path from any input.

Reset
REQ-032 CPU_RESETN = 0 shall immediately (asynchronously) force the following, regardless of the current state or a step in progress:
- state HOLD, hold counter 0, cpu_rst 1, cpu_ce 0;
- mode 00, step_cnt 0, beat 0, divider 0;
- debounced values 0 and synchronizer flops 0.
REQ-033 Reset release shall be synchronized internally, so the HOLD count starts on the second rising edge after deassertion.

Verification
REQ-034 DEB_CYCLES=4, BASE_DIV=100, run_sw=0; release reset -> cpu_rst high for 16 cycles, then mode=01 and cpu_ce never asserts.
REQ-035 PAUSE, step_btn pressed for 10 cycles with 2-cycle glitches before it -> exactly one cpu_ce pulse, step_cnt=1, beat=1.
REQ-036 run_sw=1, speed_sel=00 -> mode=10 and cpu_ce pulses exactly every 100 cycles; switching to speed_sel=01 mid-count -> next pulse 10 cycles later.
REQ-037 RUN, speed_sel=11, halt_req asserted for 1 cycle -> mode=11 on the next edge and cpu_ce=0 from that cycle on.
- A step with run_sw=1 leaves the FSM in HALT; a step with run_sw=0 gives mode=01 with no pulse.
REQ-038 Force step_cnt to 0xFFFF, then one step -> step_cnt=0x0000.
REQ-039 CPU_RESETN pulled low mid-RUN between clock edges -> outputs reset values within the same cycle, with no further cpu_ce pulses.
